// File: rtl/mc_control_pkg.sv
// mc_control_pkg
//   Shared definitions for the multi-cycle controller: state encoding,
//   instruction opcode / function-code constants, ALU operation codes,
//   the decoded instruction class and the trap cause.
package mc_control_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  // Instruction class latched in DECODE; everything after DECODE keys off it.
  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_ADDI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_JUMP,
    CLS_ILL
  } instr_cls_e;

  typedef enum logic [1:0] {
    CAUSE_NONE,
    CAUSE_ILLEGAL,
    CAUSE_TIMEOUT
  } trap_cause_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Wait-counter value seen on the 16th consecutive not-ready MEM cycle.
  localparam logic [3:0] WAIT_LAST = 4'd15;

endpackage

// File: rtl/mc_control_if.sv
// mc_control_if
//   Bundles the controller's instruction / memory inputs and its control
//   outputs. The slave modport is the controller's view; the master modport
//   is the view of whatever drives the instruction register and memory.
//   Inputs : INT, memReady, opCode[5:0], fnCode[5:0]
//   Outputs: PCWrite, loadEntry, IRWrite, RegDst, RegWrite, ALUSrc, Mem2Reg,
//            MemRead, MemWrite, branch, jump, op[2:0], state[2:0],
//            instrDone, illegal, memTimeout, retired[15:0]
interface mc_control_if;
  logic        INT;
  logic        memReady;
  logic [5:0]  opCode;
  logic [5:0]  fnCode;
  logic        PCWrite, loadEntry, IRWrite;
  logic        RegDst, RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite, branch, jump;
  logic [2:0]  op;
  logic [2:0]  state;
  logic        instrDone, illegal, memTimeout;
  logic [15:0] retired;

  modport master (
    output INT, memReady, opCode, fnCode,
    input  PCWrite, loadEntry, IRWrite, RegDst, RegWrite, ALUSrc, Mem2Reg,
           MemRead, MemWrite, branch, jump, op, state, instrDone, illegal,
           memTimeout, retired
  );

  modport slave (
    input  INT, memReady, opCode, fnCode,
    output PCWrite, loadEntry, IRWrite, RegDst, RegWrite, ALUSrc, Mem2Reg,
           MemRead, MemWrite, branch, jump, op, state, instrDone, illegal,
           memTimeout, retired
  );
endinterface

// File: rtl/alu_op_dec.sv
// alu_op_dec
//   Purely combinational instruction decode: classifies opCode/fnCode and
//   selects the ALU operation the instruction uses in EXEC.
//   Inputs : i_opcode[5:0], i_fncode[5:0]
//   Outputs: o_op[2:0] ALU operation, o_cls instruction class (CLS_ILL when
//            the opcode or the R-type function code is not supported)
module alu_op_dec
  import mc_control_pkg::*;
(
  input  logic [5:0]  i_opcode,
  input  logic [5:0]  i_fncode,
  output logic [2:0]  o_op,
  output instr_cls_e  o_cls
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    o_op  = ALU_ADD;
    o_cls = CLS_ILL;
    case (i_opcode)
      OP_RTYPE: begin
        o_cls = CLS_RTYPE;
        case (i_fncode)
          FN_ADD:  o_op = ALU_ADD;
          FN_SUB:  o_op = ALU_SUB;
          FN_AND:  o_op = ALU_AND;
          FN_OR:   o_op = ALU_OR;
          FN_SLT:  o_op = ALU_SLT;
          default: o_cls = CLS_ILL;
        endcase
      end
      OP_J, OP_JAL: o_cls = CLS_JUMP;   // jal is treated as a plain jump: no link
      OP_BEQ: begin
        o_cls = CLS_BEQ;
        o_op  = ALU_SUB;
      end
      OP_ADDI: o_cls = CLS_ADDI;
      OP_LW:   o_cls = CLS_LW;
      OP_SW:   o_cls = CLS_SW;
      default: o_cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// mc_control
//   Multi-cycle controller: IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB]
//   with a sticky TRAP for illegal instructions and memory timeouts.
//   Control outputs are decoded from the registered state, the instruction
//   class latched in DECODE, and the two live handshake inputs (INT in IDLE,
//   memReady in MEM). retired counts instruction boundaries (instrDone).
//   Ports: clk, rst (async, active-high), bus (mc_control_if.slave)
module mc_control
  import mc_control_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  mc_control_if.slave  bus
);

  state_e      r_state;
  instr_cls_e  r_cls;
  logic [2:0]  r_alu;
  logic [3:0]  r_wait;
  logic        r_pend;
  trap_cause_e r_cause;
  logic [15:0] r_retired;

  logic [2:0]  w_dec_op;
  instr_cls_e  w_dec_cls;
  logic        w_pcw, w_le, w_irw, w_rdst, w_rw, w_alusrc, w_m2r;
  logic        w_mr, w_mw, w_branch, w_jump, w_done, w_ill, w_mto;
  logic [2:0]  w_op;

  alu_op_dec u_alu_op_dec (
    .i_opcode (bus.opCode),
    .i_fncode (bus.fnCode),
    .o_op     (w_dec_op),
    .o_cls    (w_dec_cls)
  );

  always_comb begin
    w_pcw = 1'b0;  w_le  = 1'b0;  w_irw    = 1'b0;  w_rdst = 1'b0;
    w_rw  = 1'b0;  w_m2r = 1'b0;  w_alusrc = 1'b0;  w_mr   = 1'b0;
    w_mw  = 1'b0;  w_branch = 1'b0;  w_jump = 1'b0;  w_done = 1'b0;
    w_ill = 1'b0;  w_mto = 1'b0;  w_op = ALU_ADD;
    case (r_state)
      // rst gating keeps loadEntry/PCWrite low while reset is held with INT=1.
      S_IDLE: if (bus.INT && !rst) begin
        w_le  = 1'b1;
        w_pcw = 1'b1;
      end
      S_FETCH: w_irw = 1'b1;
      S_EXEC: begin
        w_op = r_alu;
        case (r_cls)
          CLS_ADDI, CLS_LW, CLS_SW: w_alusrc = 1'b1;
          CLS_BEQ: begin
            w_branch = 1'b1;  w_pcw = 1'b1;  w_done = 1'b1;
          end
          CLS_JUMP: begin
            w_jump = 1'b1;  w_pcw = 1'b1;  w_done = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        w_mr = (r_cls == CLS_LW);
        w_mw = (r_cls == CLS_SW);
        if (bus.memReady) begin
          if (r_cls == CLS_SW) begin
            w_pcw  = 1'b1;
            w_done = 1'b1;
          end
        end else if (r_wait == WAIT_LAST) begin
          w_mto = 1'b1;
        end
      end
      S_WB: begin
        w_rw   = 1'b1;  w_pcw = 1'b1;  w_done = 1'b1;
        w_rdst = (r_cls == CLS_RTYPE);
        w_m2r  = (r_cls == CLS_LW);
      end
      S_TRAP: begin
        w_ill = (r_cause == CAUSE_ILLEGAL);
        w_mto = (r_cause == CAUSE_TIMEOUT);
      end
      default: ;
    endcase
    // A pending entry request is serviced at the instruction boundary.
    if (w_done && r_pend) w_le = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cls     <= CLS_ILL;
      r_alu     <= ALU_ADD;
      r_wait    <= '0;
      r_pend    <= 1'b0;
      r_cause   <= CAUSE_NONE;
      r_retired <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      // A new INT outside IDLE (including one on a boundary) arms the next boundary.
      r_pend <= (r_pend && !w_done) || (bus.INT && (r_state != S_IDLE));
      if (w_done) r_retired <= r_retired + 16'd1;
      case (r_state)
        S_IDLE:  if (bus.INT) r_state <= S_FETCH;
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          r_cls <= w_dec_cls;
          r_alu <= w_dec_op;
          if (w_dec_cls == CLS_ILL) begin
            r_cause <= CAUSE_ILLEGAL;
            r_state <= S_TRAP;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (r_cls)
            CLS_LW, CLS_SW: begin
              r_wait  <= '0;
              r_state <= S_MEM;
            end
            CLS_BEQ, CLS_JUMP: r_state <= S_FETCH;
            default:           r_state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (bus.memReady) begin
            if (r_cls == CLS_LW) r_state <= S_WB;
            else                 r_state <= S_FETCH;
          end else if (r_wait == WAIT_LAST) begin
            r_cause <= CAUSE_TIMEOUT;
            r_state <= S_TRAP;
          end else begin
            r_wait <= r_wait + 4'd1;
          end
        end
        S_WB:    r_state <= S_FETCH;
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.PCWrite    = w_pcw;
  assign bus.loadEntry  = w_le;
  assign bus.IRWrite    = w_irw;
  assign bus.RegDst     = w_rdst;
  assign bus.RegWrite   = w_rw;
  assign bus.ALUSrc     = w_alusrc;
  assign bus.Mem2Reg    = w_m2r;
  assign bus.MemRead    = w_mr;
  assign bus.MemWrite   = w_mw;
  assign bus.branch     = w_branch;
  assign bus.jump       = w_jump;
  assign bus.op         = w_op;
  assign bus.state      = r_state;
  assign bus.instrDone  = w_done;
  assign bus.illegal    = w_ill;
  assign bus.memTimeout = w_mto;
  assign bus.retired    = r_retired;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control
//   Bench for mc_control: a cycle-by-cycle vector table for a short program,
//   hand sequences for TRAP, timeout and reset corners, and a randomized
//   instruction stream checked against an instruction-level reference model.
module tb_mc_control;
  import mc_control_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mc_control_if bus ();
  mc_control dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  // Flag bit positions of the 14 single-bit outputs.
  localparam logic [13:0] PCW  = 14'h0001, LE   = 14'h0002, IRW  = 14'h0004;
  localparam logic [13:0] RDST = 14'h0008, RW   = 14'h0010, ASRC = 14'h0020;
  localparam logic [13:0] M2R  = 14'h0040, MR   = 14'h0080, MW   = 14'h0100;
  localparam logic [13:0] BR   = 14'h0200, JP   = 14'h0400, DONE = 14'h0800;
  localparam logic [13:0] ILL  = 14'h1000, MTO  = 14'h2000;

  typedef struct {
    logic        i_int;
    logic        rdy;
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [2:0]  st;
    logic [2:0]  op;
    logic [13:0] fl;
    logic [15:0] ret;
  } vec_t;
  vec_t vt[$];

  // Random-stream instruction menu: add sub and or slt addi lw sw beq j jal.
  logic [5:0] k_opc [11] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08,
                             6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};
  logic [5:0] k_fn  [5]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  logic [2:0] k_op  [11] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010,
                             3'b010, 3'b010, 3'b110, 3'b010, 3'b010};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [13:0] flags();
    return {bus.memTimeout, bus.illegal, bus.instrDone, bus.jump, bus.branch,
            bus.MemWrite, bus.MemRead, bus.Mem2Reg, bus.ALUSrc, bus.RegWrite,
            bus.RegDst, bus.IRWrite, bus.loadEntry, bus.PCWrite};
  endfunction

  function automatic logic [35:0] obs();
    return {bus.state, bus.op, flags(), bus.retired};
  endfunction

  // One clock: inputs change 2 ns after the rising edge, outputs sampled 1 ns later.
  task automatic step(input logic i_int, input logic rdy, input logic [5:0] opc, input logic [5:0] fn);
    @(posedge clk);
    #2;
    bus.INT = i_int;  bus.memReady = rdy;  bus.opCode = opc;  bus.fnCode = fn;
    #1;
  endtask

  // Asserts rst between edges, checks the immediate effect, releases on a falling edge.
  task automatic do_reset(input string name);
    bus.INT = 1'b0;  bus.memReady = 1'b0;  bus.opCode = '0;  bus.fnCode = '0;
    rst = 1'b1;
    #1;
    check(name, {28'h0, obs()}, {28'h0, S_IDLE, 3'b010, 14'h0, 16'h0});
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic add_vec(input logic i_int, input logic rdy, input logic [5:0] opc, input logic [5:0] fn,
                         input logic [2:0] st, input logic [2:0] op, input logic [13:0] fl, input logic [15:0] ret);
    vec_t v;
    v.i_int = i_int; v.rdy = rdy; v.opc = opc; v.fn = fn;
    v.st = st; v.op = op; v.fl = fl; v.ret = ret;
    vt.push_back(v);
  endtask

  task automatic build_table();
    add_vec(1, 0, 6'h00, 6'h20, S_IDLE,   3'b010, PCW | LE, 0);
    // add
    add_vec(0, 0, 6'h00, 6'h20, S_FETCH,  3'b010, IRW, 0);
    add_vec(0, 0, 6'h00, 6'h20, S_DECODE, 3'b010, 0, 0);
    add_vec(0, 0, 6'h00, 6'h20, S_EXEC,   3'b010, 0, 0);
    add_vec(0, 0, 6'h00, 6'h20, S_WB,     3'b010, RW | RDST | PCW | DONE, 0);
    // lw, memReady low for 3 cycles
    add_vec(0, 0, 6'h23, 6'h00, S_FETCH,  3'b010, IRW, 1);
    add_vec(0, 0, 6'h23, 6'h00, S_DECODE, 3'b010, 0, 1);
    add_vec(0, 0, 6'h23, 6'h00, S_EXEC,   3'b010, ASRC, 1);
    add_vec(0, 0, 6'h23, 6'h00, S_MEM,    3'b010, MR, 1);
    add_vec(0, 0, 6'h23, 6'h00, S_MEM,    3'b010, MR, 1);
    add_vec(0, 0, 6'h23, 6'h00, S_MEM,    3'b010, MR, 1);
    add_vec(0, 1, 6'h23, 6'h00, S_MEM,    3'b010, MR, 1);
    add_vec(0, 0, 6'h23, 6'h00, S_WB,     3'b010, RW | M2R | PCW | DONE, 1);
    // sw, memReady high at once
    add_vec(0, 0, 6'h2B, 6'h00, S_FETCH,  3'b010, IRW, 2);
    add_vec(0, 0, 6'h2B, 6'h00, S_DECODE, 3'b010, 0, 2);
    add_vec(0, 0, 6'h2B, 6'h00, S_EXEC,   3'b010, ASRC, 2);
    add_vec(0, 1, 6'h2B, 6'h00, S_MEM,    3'b010, MW | PCW | DONE, 2);
    // beq with INT on its boundary: no load now, load at the next boundary
    add_vec(0, 0, 6'h04, 6'h00, S_FETCH,  3'b010, IRW, 3);
    add_vec(0, 0, 6'h04, 6'h00, S_DECODE, 3'b010, 0, 3);
    add_vec(1, 0, 6'h04, 6'h00, S_EXEC,   3'b110, BR | PCW | DONE, 3);
    // j
    add_vec(0, 0, 6'h02, 6'h00, S_FETCH,  3'b010, IRW, 4);
    add_vec(0, 0, 6'h02, 6'h00, S_DECODE, 3'b010, 0, 4);
    add_vec(0, 0, 6'h02, 6'h00, S_EXEC,   3'b010, JP | PCW | DONE | LE, 4);
    // sub with INT pulsed in EXEC
    add_vec(0, 0, 6'h00, 6'h22, S_FETCH,  3'b010, IRW, 5);
    add_vec(0, 0, 6'h00, 6'h22, S_DECODE, 3'b010, 0, 5);
    add_vec(1, 0, 6'h00, 6'h22, S_EXEC,   3'b110, 0, 5);
    add_vec(0, 0, 6'h00, 6'h22, S_WB,     3'b010, RW | RDST | PCW | DONE | LE, 5);
    // addi
    add_vec(0, 0, 6'h08, 6'h3F, S_FETCH,  3'b010, IRW, 6);
    add_vec(0, 0, 6'h08, 6'h3F, S_DECODE, 3'b010, 0, 6);
    add_vec(0, 0, 6'h08, 6'h3F, S_EXEC,   3'b010, ASRC, 6);
    add_vec(0, 0, 6'h08, 6'h3F, S_WB,     3'b010, RW | PCW | DONE, 6);
    // and, or, slt
    add_vec(0, 0, 6'h00, 6'h24, S_FETCH,  3'b010, IRW, 7);
    add_vec(0, 0, 6'h00, 6'h24, S_DECODE, 3'b010, 0, 7);
    add_vec(0, 0, 6'h00, 6'h24, S_EXEC,   3'b000, 0, 7);
    add_vec(0, 0, 6'h00, 6'h24, S_WB,     3'b010, RW | RDST | PCW | DONE, 7);
    add_vec(0, 0, 6'h00, 6'h25, S_FETCH,  3'b010, IRW, 8);
    add_vec(0, 0, 6'h00, 6'h25, S_DECODE, 3'b010, 0, 8);
    add_vec(0, 0, 6'h00, 6'h25, S_EXEC,   3'b001, 0, 8);
    add_vec(0, 0, 6'h00, 6'h25, S_WB,     3'b010, RW | RDST | PCW | DONE, 8);
    add_vec(0, 0, 6'h00, 6'h2A, S_FETCH,  3'b010, IRW, 9);
    add_vec(0, 0, 6'h00, 6'h2A, S_DECODE, 3'b010, 0, 9);
    add_vec(0, 0, 6'h00, 6'h2A, S_EXEC,   3'b111, 0, 9);
    add_vec(0, 0, 6'h00, 6'h2A, S_WB,     3'b010, RW | RDST | PCW | DONE, 9);
    // jal: jump, no link write
    add_vec(0, 0, 6'h03, 6'h00, S_FETCH,  3'b010, IRW, 10);
    add_vec(0, 0, 6'h03, 6'h00, S_DECODE, 3'b010, 0, 10);
    add_vec(0, 0, 6'h03, 6'h00, S_EXEC,   3'b010, JP | PCW | DONE, 10);
    // illegal opcode 0x3F heads for TRAP
    add_vec(0, 0, 6'h3F, 6'h00, S_FETCH,  3'b010, IRW, 11);
    add_vec(0, 0, 6'h3F, 6'h00, S_DECODE, 3'b010, 0, 11);
  endtask

  task automatic run_table();
    build_table();
    foreach (vt[i]) begin
      step(vt[i].i_int, vt[i].rdy, vt[i].opc, vt[i].fn);
      check($sformatf("vec[%0d]", i), {28'h0, obs()},
            {28'h0, vt[i].st, vt[i].op, vt[i].fl, vt[i].ret});
    end
    // Sticky TRAP: illegal held, strobes low, INT/memReady ignored.
    for (int c = 0; c < 20; c++) begin
      step(1'($urandom), 1'($urandom), 6'h3F, 6'h00);
      check($sformatf("trap_hold[%0d]", c), {28'h0, obs()},
            {28'h0, S_TRAP, 3'b010, ILL, 16'd11});
    end
    do_reset("rst_mid_trap");
    // R-type with unsupported fnCode
    step(1, 0, 6'h00, 6'h01);
    step(0, 0, 6'h00, 6'h01);
    step(0, 0, 6'h00, 6'h01);
    step(0, 0, 6'h00, 6'h01);
    check("trap_bad_fn", {28'h0, obs()}, {28'h0, S_TRAP, 3'b010, ILL, 16'd0});
  endtask

  task automatic run_timeout();
    int k;
    logic found;
    do_reset("rst_before_timeout");
    step(1, 0, 6'h23, 6'h00);
    step(0, 0, 6'h23, 6'h00);
    step(0, 0, 6'h23, 6'h00);
    step(0, 0, 6'h23, 6'h00);   // EXEC
    k = 0;
    found = 1'b0;
    for (int i = 1; i <= 40 && !found; i++) begin
      step(0, 0, 6'h23, 6'h00);
      if (bus.memTimeout) begin
        found = 1'b1;
        k = i;
      end
    end
    check("timeout_cycle", k, 16);
    check("timeout_in_mem", {bus.state, bus.MemRead}, {S_MEM, 1'b1});
    step(0, 0, 6'h23, 6'h00);
    check("timeout_trap", {28'h0, obs()}, {28'h0, S_TRAP, 3'b010, MTO, 16'd0});
    step(1, 1, 6'h23, 6'h00);
    check("timeout_trap_hold", {28'h0, obs()}, {28'h0, S_TRAP, 3'b010, MTO, 16'd0});

    // memReady on the 16th not-ready-counted cycle wins; counter restarts per access.
    do_reset("rst_before_ready16");
    step(1, 0, 6'h23, 6'h00);
    for (int rep = 0; rep < 2; rep++) begin
      step(0, 0, 6'h23, 6'h00);
      step(0, 0, 6'h23, 6'h00);
      step(0, 0, 6'h23, 6'h00);
      for (int i = 0; i < 15; i++) step(0, 0, 6'h23, 6'h00);
      step(0, 1, 6'h23, 6'h00);
      check($sformatf("ready16_mem[%0d]", rep),
            {bus.state, bus.memTimeout, bus.MemRead}, {S_MEM, 1'b0, 1'b1});
      step(0, 0, 6'h23, 6'h00);
      check($sformatf("ready16_wb[%0d]", rep),
            {bus.state, bus.Mem2Reg, bus.RegWrite}, {S_WB, 1'b1, 1'b1});
    end
    step(0, 0, 6'h23, 6'h00);
    check("ready16_retired", bus.retired, 16'd2);
    step(0, 0, 6'h23, 6'h00);
    step(0, 0, 6'h23, 6'h00);
    step(0, 0, 6'h23, 6'h00);
    step(0, 0, 6'h23, 6'h00);
    do_reset("rst_mid_mem");
  endtask

  // Instruction-level reference: each instruction is a list of phases, the
  // last phase is the boundary; an entry request is remembered until one.
  task automatic run_random();
    state_e     ph[$];
    int         k, lat, mem_i;
    logic [5:0] fn;
    logic       req, i_int, rdy, bnd, in_ex, in_mem, in_wb;
    logic [15:0] ret;
    logic [15:0] exp_ctl;
    do_reset("rst_before_random");
    step(1, 0, 6'h00, 6'h20);
    check("rand_idle_entry", {bus.loadEntry, bus.PCWrite}, 2'b11);
    req = 1'b0;
    ret = 16'd0;
    for (int n = 0; n < 150; n++) begin
      k   = $urandom_range(0, 10);
      lat = $urandom_range(0, 15);
      fn  = (k < 5) ? k_fn[k] : 6'($urandom);
      ph  = {};
      ph.push_back(S_FETCH);
      ph.push_back(S_DECODE);
      ph.push_back(S_EXEC);
      if (k == 6 || k == 7) for (int m = 0; m <= lat; m++) ph.push_back(S_MEM);
      if (k <= 6) ph.push_back(S_WB);
      mem_i = 0;
      for (int c = 0; c < ph.size(); c++) begin
        bnd    = (c == ph.size() - 1);
        in_ex  = (ph[c] == S_EXEC);
        in_mem = (ph[c] == S_MEM);
        in_wb  = (ph[c] == S_WB);
        i_int  = ($urandom_range(0, 7) == 0);
        if (in_mem) begin
          rdy = (mem_i == lat);
          mem_i++;
        end else begin
          rdy = 1'($urandom);
        end
        step(i_int, rdy, k_opc[k], fn);
        exp_ctl = {bnd, bnd && req, bnd, ph[c] == S_FETCH, in_wb, in_wb && k < 5,
                   in_wb && k == 6, in_mem && k == 6, in_mem && k == 7,
                   in_ex && k == 8, in_ex && k >= 9, in_ex && (k >= 5 && k <= 7),
                   in_ex ? k_op[k] : 3'b010};
        check("rand_state", bus.state, ph[c]);
        check("rand_ctl",
              {bus.instrDone, bus.loadEntry, bus.PCWrite, bus.IRWrite, bus.RegWrite,
               bus.RegDst, bus.Mem2Reg, bus.MemRead, bus.MemWrite, bus.branch,
               bus.jump, bus.ALUSrc, bus.op}, exp_ctl);
        check("rand_retired", bus.retired, ret);
        check("rand_exclusive", {bus.MemRead & bus.MemWrite, bus.branch & bus.jump}, 2'b00);
        req = (req && !bnd) || i_int;
        if (bnd) ret = ret + 16'd1;
      end
    end
  endtask

  initial begin
    bus.INT = 1'b0;  bus.memReady = 1'b0;  bus.opCode = '0;  bus.fnCode = '0;
    #1;
    do_reset("rst_initial");
    run_table();
    run_timeout();
    run_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
